vid_seg_packer: RTL and testbench
=================================

# vid_seg_packer

Sits directly downstream of the HDMI receive timing stage. Takes the recovered 24-bit RGB pixel stream, qualified by `video_en`, together with the line counter and segment index that stage produces, and packs it into 48-bit FIFO words for the Ethernet transmit path. Each active line is cut into fixed-length segments. Each segment is preceded by one header word. When the FIFO cannot absorb a whole segment, that segment is dropped complete.

## Interface
Parameters:
- `SEG_PIX`, 640: pixels per segment; even, 2..2046.
- `MAGIC`, 8'hA5: header tag byte.

Ports:
- `rx0_pclk`  in  1  pixel clock; the only clock.
- `rstbtn_n`  in  1  reset, asynchronous, active-low.
- `video_en`  in  1  active-pixel qualifier from timing stage.
- `video_vcnt`  in  11  active line number.
- `index`  in  12  segment index from timing stage.
- `rx0_red`, `rx0_green`, `rx0_blue`  in  8 each  pixel data, valid when `video_en`=1.
- `fifo_afull`  in  1  FIFO has fewer than SEG_PIX/2+1 free words.
- `fifo_full`  in  1  FIFO full.
- `fifo_din`  out  48  write data.
- `fifo_wr_en`  out  1  write strobe.
- `drop_cnt`  out  16  dropped segments, saturating.
- `ovf`  out  1  sticky: a write was attempted while `fifo_full`=1.

## Operation
- A pixel is `{red, green, blue}`. Word packing: `{first pixel, second pixel}`, with the first pixel in bits [47:24].
- Header fields: [47:40]=MAGIC, [39:28]=`index`, [27:17]=`video_vcnt` (both sampled on the segment's first pixel), [16:7]=SEG_PIX/2, [6:0]=0.
- `pix_cnt` is 11 bits and counts pixels within the segment.
- States and transitions:
  - IDLE, `video_en`=1, `fifo_afull`=1: go to DROP, `pix_cnt`=1, increment `drop_cnt`.
  - IDLE, `video_en`=1, `fifo_afull`=0: write header, latch pixel as low half, `pix_cnt`=1, go to HI.
  - LO, `video_en`=1: latch pixel, `pix_cnt`+1, go to HI.
  - LO, `video_en`=0: go to IDLE.
  - HI, `video_en`=1: write {lo, pixel} and `pix_cnt`+1. If the new count equals SEG_PIX, go to IDLE; otherwise go to LO.
  - HI, `video_en`=0: write {lo, 24'h0} as padding, go to IDLE.
  - DROP: count pixels; no writes. Go to IDLE when `video_en`=0 or the count reaches SEG_PIX.
- After a segment completes, the next pixel in IDLE starts a new segment with no gap cycle.
- Any write issued while `fifo_full`=1 is still strobed. Set `ovf`. `ovf` clears only on reset.
- `drop_cnt` saturates at 16'hFFFF.

## Timing
- All outputs are registered. A header is written 1 cycle after the segment's first pixel. A pair word is written 1 cycle after its second pixel.
- At most one write per cycle. The header takes the first-pixel slot and data takes the second-pixel slot, so no internal buffering is needed.
- `fifo_afull` is sampled only in IDLE. Its later changes do not abort a segment.
- Reset values: state IDLE, `fifo_wr_en`=0, `fifo_din`=0, `drop_cnt`=0, `ovf`=0, `pix_cnt`=0.
- Reset asserted mid-segment abandons the partial segment immediately, with no padding write.
- On `video_en` falling in LO, no write occurs; the last pair has already been written.

## Configuration
- `VIDPACK_STATS_EN`
  - Defined: `drop_cnt` and `ovf` behave as above.
  - Undefined: both outputs are tied to 0 and their registers are not built. Drop and packing behaviour are unchanged.

## Structure
- Shared package `vidpack_pkg`: state encoding (IDLE, LO, HI, DROP), header field positions, default MAGIC, pixel width constant 24.
- Single module, no sub-modules.

## Test plan
- 1280-pixel line, `fifo_afull`=0, `index`=5 then 6, `video_vcnt`=3 → 2×(header + 320 words). Headers are 48'hA5_005_003_140_00 and …006… (field-exact). Data words are in pixel order.
- 1281-pixel line → third segment is header + 1 word {p1280, 24'h0}.
- `fifo_afull`=1 at the first segment start, then 0 → zero writes for the first 640 pixels, `drop_cnt`=1, second segment emitted normally.
- `fifo_full`=1 for one cycle mid-payload → `ovf`=1 and stays set. The word count is unchanged.
- Reset pulsed during pixel 100 → outputs return to reset values within the same cycle. The next `video_en` rise starts a fresh header.
- Build without `VIDPACK_STATS_EN`, repeat the drop test → `drop_cnt`=0, `ovf`=0, write pattern identical.

Source files
------------

// File: rtl/vidpack_pkg.sv
// Shared definitions for the video segment packer: FSM encoding, header layout, pixel width.
package vidpack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DROP = 2'd3
  } vp_state_e;

  localparam int         PIX_W         = 24;
  localparam logic [7:0] MAGIC_DEF     = 8'hA5;
  localparam int         HDR_MAGIC_LSB = 40;
  localparam int         HDR_INDEX_LSB = 28;
  localparam int         HDR_VCNT_LSB  = 17;
  localparam int         HDR_LEN_LSB   = 7;

  // Low seven bits of the header stay zero.
  function automatic logic [47:0] make_header(input logic [7:0]  magic,
                                              input logic [11:0] idx,
                                              input logic [10:0] vcnt,
                                              input logic [9:0]  len);
    make_header = (48'(magic) << HDR_MAGIC_LSB) |
                  (48'(idx)   << HDR_INDEX_LSB) |
                  (48'(vcnt)  << HDR_VCNT_LSB)  |
                  (48'(len)   << HDR_LEN_LSB);
  endfunction

endpackage

// File: rtl/vid_seg_packer.sv
// Packs the 24-bit pixel stream into 48-bit FIFO words, one header per segment.
// Optional statistics (drop_cnt, ovf) are built only when VIDPACK_STATS_EN is defined.
module vid_seg_packer
  import vidpack_pkg::*;
#(
  parameter int         SEG_PIX = 640,
  parameter logic [7:0] MAGIC   = MAGIC_DEF
) (
  input  logic        rx0_pclk,
  input  logic        rstbtn_n,
  input  logic        video_en,
  input  logic [10:0] video_vcnt,
  input  logic [11:0] index,
  input  logic [7:0]  rx0_red,
  input  logic [7:0]  rx0_green,
  input  logic [7:0]  rx0_blue,
  input  logic        fifo_afull,
  input  logic        fifo_full,
  output logic [47:0] fifo_din,
  output logic        fifo_wr_en,
  output logic [15:0] drop_cnt,
  output logic        ovf
);

  localparam logic [10:0] SEG_LEN = 11'(SEG_PIX);
  localparam logic [9:0]  HDR_LEN = 10'(SEG_PIX / 2);

  vp_state_e         state_r, state_s;
  logic [10:0]       pix_cnt_r, pix_cnt_s;
  logic [PIX_W-1:0]  lo_r, lo_s;
  logic [47:0]       fifo_din_r, din_s;
  logic              fifo_wr_en_r, wr_s;
  logic              drop_inc_s;
  logic [PIX_W-1:0]  pixel_s;
  logic [10:0]       cnt_inc_s;

  assign pixel_s   = {rx0_red, rx0_green, rx0_blue};
  assign cnt_inc_s = pix_cnt_r + 11'd1;

  // Next-state, packing and write decision.
  always_comb begin
    state_s    = state_r;
    pix_cnt_s  = pix_cnt_r;
    lo_s       = lo_r;
    din_s      = fifo_din_r;
    wr_s       = 1'b0;
    drop_inc_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (video_en) begin
          pix_cnt_s = 11'd1;
          if (fifo_afull) begin
            state_s    = ST_DROP;
            drop_inc_s = 1'b1;
          end else begin
            wr_s    = 1'b1;
            din_s   = make_header(MAGIC, index, video_vcnt, HDR_LEN);
            lo_s    = pixel_s;
            state_s = ST_HI;
          end
        end else begin
          pix_cnt_s = 11'd0;
        end
      end
      ST_LO: begin
        if (video_en) begin
          lo_s      = pixel_s;
          pix_cnt_s = cnt_inc_s;
          state_s   = ST_HI;
        end else begin
          pix_cnt_s = 11'd0;
          state_s   = ST_IDLE;
        end
      end
      ST_HI: begin
        wr_s = 1'b1;
        if (video_en) begin
          din_s     = {lo_r, pixel_s};
          pix_cnt_s = cnt_inc_s;
          if (cnt_inc_s == SEG_LEN) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_LO;
          end
        end else begin
          // Odd-length tail: pad the second half with zeros.
          din_s     = {lo_r, 24'h000000};
          pix_cnt_s = 11'd0;
          state_s   = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (video_en) begin
          pix_cnt_s = cnt_inc_s;
          if (cnt_inc_s == SEG_LEN) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_DROP;
          end
        end else begin
          pix_cnt_s = 11'd0;
          state_s   = ST_IDLE;
        end
      end
      default: begin
        pix_cnt_s = 11'd0;
        state_s   = ST_IDLE;
      end
    endcase
  end

  // Packer state and registered FIFO write port.
  always_ff @(posedge rx0_pclk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      state_r      <= ST_IDLE;
      pix_cnt_r    <= 11'd0;
      lo_r         <= 24'h000000;
      fifo_din_r   <= 48'h0;
      fifo_wr_en_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      pix_cnt_r    <= pix_cnt_s;
      lo_r         <= lo_s;
      fifo_din_r   <= din_s;
      fifo_wr_en_r <= wr_s;
    end
  end

  assign fifo_din   = fifo_din_r;
  assign fifo_wr_en = fifo_wr_en_r;

`ifdef VIDPACK_STATS_EN
  logic [15:0] drop_cnt_r;
  logic        ovf_r;

  // Saturating drop counter and sticky overflow flag (strobe seen while full).
  always_ff @(posedge rx0_pclk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      drop_cnt_r <= 16'h0000;
      ovf_r      <= 1'b0;
    end else begin
      if (drop_inc_s && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 16'd1;
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
      if (fifo_wr_en_r && fifo_full) begin
        ovf_r <= 1'b1;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  assign drop_cnt = drop_cnt_r;
  assign ovf      = ovf_r;
`else
  logic unused_stats_s;
  assign unused_stats_s = ^{drop_inc_s, fifo_full};
  assign drop_cnt       = 16'h0000;
  assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_vid_seg_packer.sv
// Scoreboard bench for vid_seg_packer: stimulus queues expected FIFO words, a monitor pops them.
module tb_vid_seg_packer;

  localparam int SEG = 640;

  logic        clk = 1'b0;
  logic        rstbtn_n;
  logic        video_en;
  logic [10:0] video_vcnt;
  logic [11:0] index;
  logic [7:0]  rx0_red, rx0_green, rx0_blue;
  logic        fifo_afull, fifo_full;
  logic [47:0] fifo_din;
  logic        fifo_wr_en;
  logic [15:0] drop_cnt;
  logic        ovf;

  int errors = 0;
  int checks = 0;
  logic [47:0] exp_q[$];

`ifdef VIDPACK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  vid_seg_packer #(.SEG_PIX(SEG), .MAGIC(8'hA5)) dut (
    .rx0_pclk   (clk),
    .rstbtn_n   (rstbtn_n),
    .video_en   (video_en),
    .video_vcnt (video_vcnt),
    .index      (index),
    .rx0_red    (rx0_red),
    .rx0_green  (rx0_green),
    .rx0_blue   (rx0_blue),
    .fifo_afull (fifo_afull),
    .fifo_full  (fifo_full),
    .fifo_din   (fifo_din),
    .fifo_wr_en (fifo_wr_en),
    .drop_cnt   (drop_cnt),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] pix(input int k, input int ln);
    logic [7:0] a, b, c;
    a = 8'(k);
    b = 8'(k >> 8) ^ 8'(ln);
    c = 8'(k * 7);
    return {a, b, c};
  endfunction

  function automatic logic [47:0] hdr(input logic [11:0] idx, input logic [10:0] vc);
    return {8'hA5, idx, vc, 10'd320, 7'd0};
  endfunction

  task automatic check(input string name, input logic [47:0] got, input logic [47:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Monitor: every strobed write must match the head of the expected queue.
  always @(negedge clk) begin
    if (rstbtn_n === 1'b1 && fifo_wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got %h expected no write", fifo_din);
      end else begin
        if (fifo_din !== exp_q[0]) begin
          errors++;
          $display("FAIL word: got %h expected %h", fifo_din, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive_pix(input logic en, input logic [23:0] p);
    video_en = en;
    {rx0_red, rx0_green, rx0_blue} = p;
    @(posedge clk);
    #1;
  endtask

  task automatic blank(input int n);
    fifo_afull = 1'b0;
    fifo_full  = 1'b0;
    for (int i = 0; i < n; i++) drive_pix(1'b0, 24'h0);
  endtask

  // One active line; segment 0 optionally sees fifo_afull, fifo_full pulses on pixel full_at.
  task automatic run_line(input int len, input logic [11:0] idx0, input logic [10:0] vc,
                          input bit afull_first, input int full_at);
    int nseg;
    nseg = (len + SEG - 1) / SEG;
    for (int s = 0; s < nseg; s++) begin
      int base, n;
      base = s * SEG;
      n = (len - base < SEG) ? (len - base) : SEG;
      if (!(afull_first && s == 0)) begin
        exp_q.push_back(hdr(idx0 + 12'(s), vc));
        for (int j = 0; j < n; j += 2)
          exp_q.push_back({pix(base + j, int'(vc)),
                           (j + 1 < n) ? pix(base + j + 1, int'(vc)) : 24'h0});
      end
    end
    video_vcnt = vc;
    for (int k = 0; k < len; k++) begin
      index      = idx0 + 12'(k / SEG);
      fifo_afull = afull_first && (k < SEG);
      fifo_full  = (k == full_at);
      drive_pix(1'b1, pix(k, int'(vc)));
    end
    blank(4);
    check("queue_drained", 48'(exp_q.size()), 48'd0);
  endtask

  initial begin
    rstbtn_n = 1'b0; video_en = 1'b0; video_vcnt = 11'd0; index = 12'd0;
    rx0_red = 8'd0; rx0_green = 8'd0; rx0_blue = 8'd0;
    fifo_afull = 1'b0; fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", 48'(fifo_wr_en), 48'd0);
    check("rst_din", fifo_din, 48'd0);
    check("rst_drop_cnt", 48'(drop_cnt), 48'd0);
    check("rst_ovf", 48'(ovf), 48'd0);
    rstbtn_n = 1'b1;
    blank(2);

    // Two full segments, index 5 then 6, then a 1281-pixel line with a padded tail.
    check("hdr_const", hdr(12'd5, 11'd3), {8'hA5, 12'h005, 11'h003, 10'h140, 7'h00});
    run_line(1280, 12'd5, 11'd3, 1'b0, -1);
    run_line(1281, 12'd10, 11'd4, 1'b0, -1);
    check("ovf_clean", 48'(ovf), 48'd0);

    // First segment dropped on fifo_afull, second emitted.
    run_line(1280, 12'd20, 11'd7, 1'b1, -1);
    check("drop_cnt", 48'(drop_cnt), STATS ? 48'd1 : 48'd0);
    check("ovf_after_drop", 48'(ovf), 48'd0);

    // fifo_full coincident with a strobed pair write.
    run_line(1280, 12'd30, 11'd8, 1'b0, 200);
    check("ovf_set", 48'(ovf), STATS ? 48'd1 : 48'd0);
    run_line(640, 12'd40, 11'd2, 1'b0, -1);
    check("ovf_sticky", 48'(ovf), STATS ? 48'd1 : 48'd0);
    check("drop_cnt_hold", 48'(drop_cnt), STATS ? 48'd1 : 48'd0);

    // Reset during pixel 100: header plus pairs through pixel 97 only.
    exp_q.push_back(hdr(12'd9, 11'd9));
    for (int j = 0; j < 98; j += 2) exp_q.push_back({pix(j, 9), pix(j + 1, 9)});
    video_vcnt = 11'd9;
    index      = 12'd9;
    for (int k = 0; k < 100; k++) drive_pix(1'b1, pix(k, 9));
    video_en = 1'b1;
    {rx0_red, rx0_green, rx0_blue} = pix(100, 9);
    rstbtn_n = 1'b0;
    #1;
    check("midrst_wr_en", 48'(fifo_wr_en), 48'd0);
    check("midrst_din", fifo_din, 48'd0);
    check("midrst_drop_cnt", 48'(drop_cnt), 48'd0);
    check("midrst_ovf", 48'(ovf), 48'd0);
    @(posedge clk);
    #1;
    video_en = 1'b0;
    @(posedge clk);
    #1;
    rstbtn_n = 1'b1;
    blank(3);
    check("midrst_queue", 48'(exp_q.size()), 48'd0);
    run_line(640, 12'd11, 11'd10, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
